peripheral_mpi_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one generic MPI bus port (addr/we/en/data_in/data_out/ack/err) of the MPI buffer among M local requesters, e.g. a core and a DMA engine.
- Provides a packet lock so a multi-word send sequence from one requester is never interleaved with accesses from another.
- Provides a per-access timeout that converts a hung slave into a bus error.
- Sits between the requesters and the MPI buffer's bus side, inside the MPI peripheral wrapper.

---
 rtl/peripheral_mpi_arb_pkg.sv | 12 +
 rtl/peripheral_mpi_rr_picker.sv | 28 ++
 rtl/peripheral_mpi_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_peripheral_mpi_bus_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_mpi_arb_pkg.sv
// Shared types and constants for the MPI bus arbiter.
package peripheral_mpi_arb_pkg;

  localparam int unsigned BUS_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

endpackage

// File: rtl/peripheral_mpi_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i, cyclically.
module peripheral_mpi_rr_picker #(
  parameter  int unsigned M  = 2,
  localparam int unsigned PW = (M > 1) ? $clog2(M) : 1
) (
  input  logic [M-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [M-1:0]  grant_o,
  output logic          valid_o
);

  int unsigned idx;

  // Cyclic search starting at the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < M; k++) begin
      idx = (32'(ptr_i) + k) % M;
      if (!valid_o && req_i[PW'(idx)]) begin
        grant_o[PW'(idx)] = 1'b1;
        valid_o           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_mpi_bus_arbiter.sv
// Round-robin arbiter sharing the MPI buffer bus port among M requesters,
// with a packet lock that holds the grant and a per-access timeout.
module peripheral_mpi_bus_arbiter
  import peripheral_mpi_arb_pkg::*;
#(
  parameter int unsigned M       = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [M*BUS_W-1:0] m_addr,
  input  logic [M-1:0]       m_we,
  input  logic [M-1:0]       m_en,
  input  logic [M-1:0]       m_lock,
  input  logic [M*BUS_W-1:0] m_data_in,
  output logic [BUS_W-1:0]   m_data_out,
  output logic [M-1:0]       m_ack,
  output logic [M-1:0]       m_err,
  output logic [BUS_W-1:0]   bus_addr,
  output logic               bus_we,
  output logic               bus_en,
  output logic [BUS_W-1:0]   bus_data_in,
  input  logic [BUS_W-1:0]   bus_data_out,
  input  logic               bus_ack,
  input  logic               bus_err,
  output logic [M-1:0]       grant,
  output logic               timeout
);

  localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;

  arb_state_e    state_q;
  logic [M-1:0]  grant_q;
  logic [PW-1:0] rr_q;
  logic [TW-1:0] cnt_q;
  logic          timeout_q;
  logic [M-1:0]  to_err_q;

  logic [M-1:0]  pick_gnt;
  logic          pick_vld;
  logic [PW-1:0] g_idx;
  logic          g_en;
  logic          g_lock;
  logic [PW-1:0] rr_next;
  logic          done;
  logic          to_hit;

  peripheral_mpi_rr_picker #(.M(M)) u_picker (
    .req_i   (m_en),
    .ptr_i   (rr_q),
    .grant_o (pick_gnt),
    .valid_o (pick_vld)
  );

  // Route the granted requester onto the bus; everything is zero when ungranted.
  always_comb begin
    g_idx       = '0;
    g_en        = 1'b0;
    g_lock      = 1'b0;
    bus_addr    = '0;
    bus_we      = 1'b0;
    bus_data_in = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (grant_q[i]) begin
        g_idx       = PW'(i);
        g_en        = m_en[i];
        g_lock      = m_lock[i];
        bus_addr    = m_addr[i*BUS_W +: BUS_W];
        bus_we      = m_we[i];
        bus_data_in = m_data_in[i*BUS_W +: BUS_W];
      end
    end
  end

  // LOCKED also drives bus_en so a locked requester skips the arbitration cycle.
  assign bus_en  = ((state_q == BUSY) || (state_q == LOCKED)) && g_en;
  assign done    = bus_en && (bus_ack || bus_err);
  assign to_hit  = (TIMEOUT != 0) && (state_q == BUSY) && bus_en && !done &&
                   (cnt_q == TW'(TIMEOUT - 1));
  assign rr_next = (32'(g_idx) == M - 1) ? '0 : g_idx + PW'(1);

  assign m_data_out = bus_data_out;
  assign m_ack      = grant_q & {M{bus_en & bus_ack}};
  assign m_err      = (grant_q & {M{bus_en & bus_err}}) | to_err_q;
  assign grant      = grant_q;
  assign timeout    = timeout_q;

  // Arbitration FSM, round-robin pointer, timeout counter and timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      to_err_q  <= '0;
    end else begin
      timeout_q <= 1'b0;
      to_err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_gnt;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!g_en || done) begin
            // Abort or completion: hold the grant only while the lock is up.
            cnt_q <= '0;
            if (done) rr_q <= rr_next;
            if (g_lock) begin
              state_q <= LOCKED;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            to_err_q  <= grant_q;
            rr_q      <= rr_next;
            cnt_q     <= '0;
            grant_q   <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        LOCKED: begin
          if (g_en) begin
            if (done) begin
              rr_q <= rr_next;
              if (!g_lock) begin
                state_q <= IDLE;
                grant_q <= '0;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= BUSY;
            end
          end else if (!g_lock) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_mpi_bus_arbiter.sv
// Bench for the MPI bus arbiter: directed scenarios followed by random traffic,
// every cycle compared against a requester-ownership reference model.
module tb_peripheral_mpi_bus_arbiter;

  localparam int unsigned M  = 2;
  localparam int unsigned TO = 8;
  localparam int unsigned TW = 4;

  logic            clk;
  logic            rst;
  logic [M*32-1:0] m_addr;
  logic [M-1:0]    m_we;
  logic [M-1:0]    m_en;
  logic [M-1:0]    m_lock;
  logic [M*32-1:0] m_data_in;
  logic [31:0]     m_data_out;
  logic [M-1:0]    m_ack;
  logic [M-1:0]    m_err;
  logic [31:0]     bus_addr;
  logic            bus_we;
  logic            bus_en;
  logic [31:0]     bus_data_in;
  logic [31:0]     bus_data_out;
  logic            bus_ack;
  logic            bus_err;
  logic [M-1:0]    grant;
  logic            timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the bus, whether they are holding it via lock,
  // how long the current access has waited, and any pending timeout report.
  int owner;
  int ptr;
  int waitc;
  int pend_err;
  bit holding;
  bit pend_to;
  logic [M-1:0] exp_ack;
  logic [M-1:0] exp_err;
  int hang;

  peripheral_mpi_bus_arbiter #(.M(M), .TIMEOUT(TO), .TW(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_addr       (m_addr),
    .m_we         (m_we),
    .m_en         (m_en),
    .m_lock       (m_lock),
    .m_data_in    (m_data_in),
    .m_data_out   (m_data_out),
    .m_ack        (m_ack),
    .m_err        (m_err),
    .bus_addr     (bus_addr),
    .bus_we       (bus_we),
    .bus_en       (bus_en),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .bus_ack      (bus_ack),
    .bus_err      (bus_err),
    .grant        (grant),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner    = -1;
    ptr      = 0;
    waitc    = 0;
    pend_err = -1;
    holding  = 1'b0;
    pend_to  = 1'b0;
    exp_ack  = '0;
    exp_err  = '0;
  endtask

  task automatic drive(input logic [M-1:0] en, input logic ack, input logic err);
    m_en    = en;
    bus_ack = ack;
    bus_err = err;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return after the rising edge.
  task automatic step();
    logic [M-1:0] eg;
    logic [31:0]  ea, ed;
    logic         ew, ebe, dn;
    @(negedge clk);
    eg = '0; ea = '0; ed = '0; ew = 1'b0; ebe = 1'b0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      ebe = m_en[owner];
      ea  = m_addr[owner*32 +: 32];
      ed  = m_data_in[owner*32 +: 32];
      ew  = m_we[owner];
    end
    dn = ebe && (bus_ack || bus_err);
    exp_ack = '0;
    exp_err = '0;
    if (dn && bus_ack) exp_ack[owner] = 1'b1;
    if (dn && bus_err) exp_err[owner] = 1'b1;
    if (pend_err >= 0) exp_err[pend_err] = 1'b1;
    chk("grant",       32'(grant),   32'(eg));
    chk("bus_en",      32'(bus_en),  32'(ebe));
    chk("bus_addr",    bus_addr,     ea);
    chk("bus_we",      32'(bus_we),  32'(ew));
    chk("bus_data_in", bus_data_in,  ed);
    chk("m_ack",       32'(m_ack),   32'(exp_ack));
    chk("m_err",       32'(m_err),   32'(exp_err));
    chk("timeout",     32'(timeout), 32'(pend_to));
    chk("m_data_out",  m_data_out,   bus_data_out);

    pend_to  = 1'b0;
    pend_err = -1;
    if (owner < 0) begin
      for (int k = 0; k < int'(M); k++)
        if (owner < 0 && m_en[(ptr + k) % int'(M)]) owner = (ptr + k) % int'(M);
      waitc   = 0;
      holding = 1'b0;
    end else if (holding) begin
      if (m_en[owner]) begin
        if (dn) begin
          ptr = (owner + 1) % int'(M);
          if (!m_lock[owner]) owner = -1;
        end else begin
          holding = 1'b0;
          waitc   = 0;
        end
      end else if (!m_lock[owner]) begin
        owner = -1;
      end
    end else if (!m_en[owner]) begin
      waitc = 0;
      if (m_lock[owner]) holding = 1'b1;
      else owner = -1;
    end else if (dn) begin
      ptr   = (owner + 1) % int'(M);
      waitc = 0;
      if (m_lock[owner]) holding = 1'b1;
      else owner = -1;
    end else if (waitc == int'(TO) - 1) begin
      pend_to  = 1'b1;
      pend_err = owner;
      ptr      = (owner + 1) % int'(M);
      owner    = -1;
    end else begin
      waitc++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m_addr = '0; m_we = '0; m_en = '0; m_lock = '0; m_data_in = '0;
    bus_data_out = '0; bus_ack = 1'b0; bus_err = 1'b0;
    hang = 0;
    model_reset();

    // Reset values
    #2;
    chk("rst_grant",   32'(grant),   32'h0);
    chk("rst_bus_en",  32'(bus_en),  32'h0);
    chk("rst_m_ack",   32'(m_ack),   32'h0);
    chk("rst_m_err",   32'(m_err),   32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_addr",    bus_addr,     32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Simultaneous requests: requester 0 first, then requester 1
    m_addr[0 +: 32] = 32'h100; m_addr[32 +: 32] = 32'h200;
    m_data_in[0 +: 32] = 32'hA0; m_data_in[32 +: 32] = 32'hB0;
    m_we = 2'b11;
    drive(2'b11, 1'b0, 1'b0); #1;
    chk("t1_arb_grant", 32'(grant),  32'h0);
    chk("t1_arb_en",    32'(bus_en), 32'h0);
    step();
    drive(2'b11, 1'b1, 1'b0); #1;
    chk("t1_grant0", 32'(grant), 32'h1);
    chk("t1_addr0",  bus_addr,   32'h100);
    chk("t1_ack0",   32'(m_ack), 32'h1);
    step();
    drive(2'b10, 1'b0, 1'b0); #1;
    chk("t1_arb2_grant", 32'(grant), 32'h0);
    step();
    drive(2'b10, 1'b1, 1'b0); #1;
    chk("t1_grant1", 32'(grant), 32'h2);
    chk("t1_addr1",  bus_addr,   32'h200);
    chk("t1_ack1",   32'(m_ack), 32'h2);
    step();
    drive(2'b00, 1'b0, 1'b0);
    step();

    // Packet lock: four back-to-back writes from requester 0
    m_lock = 2'b01;
    m_addr[0 +: 32] = 32'h0;
    m_data_in[0 +: 32] = 32'h11;
    drive(2'b11, 1'b1, 1'b0); #1;
    chk("t2_arb_grant", 32'(grant), 32'h0);
    step();
    for (int k = 1; k <= 4; k++) begin
      m_data_in[0 +: 32] = 32'(k * 32'h11);
      if (k == 4) m_lock = 2'b00;
      drive(2'b11, 1'b1, 1'b0); #1;
      chk("t2_lock_grant", 32'(grant),  32'h1);
      chk("t2_lock_en",    32'(bus_en), 32'h1);
      chk("t2_lock_data",  bus_data_in, 32'(k * 32'h11));
      chk("t2_lock_ack",   32'(m_ack),  32'h1);
      step();
    end
    drive(2'b10, 1'b1, 1'b0); #1;
    chk("t2_rel_grant", 32'(grant),  32'h0);
    chk("t2_rel_en",    32'(bus_en), 32'h0);
    step();
    drive(2'b10, 1'b1, 1'b0); #1;
    chk("t2_r1_grant", 32'(grant), 32'h2);
    chk("t2_r1_ack",   32'(m_ack), 32'h2);
    step();
    drive(2'b00, 1'b0, 1'b0);
    step();

    // Hung slave: timeout after eight waiting cycles, then requester 1 served
    drive(2'b11, 1'b0, 1'b0);
    step();
    for (int k = 0; k < int'(TO); k++) begin
      #1;
      chk("t3_wait_en",  32'(bus_en),  32'h1);
      chk("t3_wait_to",  32'(timeout), 32'h0);
      chk("t3_wait_gnt", 32'(grant),   32'h1);
      step();
    end
    drive(2'b10, 1'b0, 1'b0); #1;
    chk("t3_to_pulse", 32'(timeout), 32'h1);
    chk("t3_to_err",   32'(m_err),   32'h1);
    chk("t3_to_en",    32'(bus_en),  32'h0);
    chk("t3_to_grant", 32'(grant),   32'h0);
    step();
    drive(2'b10, 1'b1, 1'b0); #1;
    chk("t3_next_grant", 32'(grant), 32'h2);
    chk("t3_next_ack",   32'(m_ack), 32'h2);
    step();
    drive(2'b00, 1'b0, 1'b0);
    step();

    // Ack on the would-be timeout cycle wins
    drive(2'b01, 1'b0, 1'b0);
    step();
    for (int k = 0; k < int'(TO) - 1; k++) begin
      #1;
      chk("t4_wait_en", 32'(bus_en), 32'h1);
      step();
    end
    drive(2'b01, 1'b1, 1'b0); #1;
    chk("t4_ack",    32'(m_ack),   32'h1);
    chk("t4_no_err", 32'(m_err),   32'h0);
    chk("t4_no_to",  32'(timeout), 32'h0);
    step();
    drive(2'b00, 1'b0, 1'b0); #1;
    chk("t4_after_to",  32'(timeout), 32'h0);
    chk("t4_after_err", 32'(m_err),   32'h0);
    step();

    // Read completing with a slave error
    m_we = 2'b00;
    bus_data_out = 32'hDEADBEEF;
    drive(2'b01, 1'b0, 1'b0);
    step();
    drive(2'b01, 1'b0, 1'b1); #1;
    chk("t5_err",  32'(m_err),  32'h1);
    chk("t5_ack",  32'(m_ack),  32'h0);
    chk("t5_data", m_data_out,  32'hDEADBEEF);
    step();
    drive(2'b00, 1'b0, 1'b0); #1;
    chk("t5_err_gone", 32'(m_err), 32'h0);
    step();

    // Reset in the middle of an access
    drive(2'b11, 1'b0, 1'b0);
    step();
    #1;
    chk("t6_busy_en",    32'(bus_en), 32'h1);
    chk("t6_busy_grant", 32'(grant),  32'h2);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_en",    32'(bus_en), 32'h0);
    chk("t6_rst_grant", 32'(grant),  32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    #1;
    chk("t6_post_grant", 32'(grant), 32'h1);
    drive(2'b01, 1'b1, 1'b0);
    step();
    drive(2'b00, 1'b0, 1'b0);
    step();

    // Random traffic against the model
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < int'(M); i++) begin
        if (exp_ack[i] || exp_err[i]) begin
          m_en[i] = 1'b0;
        end else if (!m_en[i]) begin
          if ($urandom_range(2) == 0) begin
            m_en[i] = 1'b1;
            m_addr[i*32 +: 32]    = $urandom;
            m_data_in[i*32 +: 32] = $urandom;
            m_we[i] = 1'($urandom_range(1));
          end
        end else if ($urandom_range(39) == 0) begin
          m_en[i] = 1'b0;
        end
        if ($urandom_range(7) == 0) m_lock[i] = ~m_lock[i];
      end
      if (hang > 0) begin
        hang--;
        bus_ack = 1'b0;
        bus_err = 1'b0;
      end else if ($urandom_range(49) == 0) begin
        hang = 12;
        bus_ack = 1'b0;
        bus_err = 1'b0;
      end else begin
        bus_ack = ($urandom_range(2) == 0);
        bus_err = ($urandom_range(7) == 0);
      end
      bus_data_out = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
